alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning datapath width (only 32 is supported).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port req_valid  input  2  per-requester operation valid (bit k = requester k).
REQ-005 The block SHALL have port req_ready  output  2  per-requester accept; at most one bit high.
REQ-006 The block SHALL have port req0_a, req0_b, req1_a, req1_b  input  N each  per-requester operands.
REQ-007 The block SHALL have port req0_control, req1_control  input  alu_control_t  per-requester ALU operation.
REQ-008 The block SHALL have port rsp_valid  output  1  response valid.
REQ-009 The block SHALL have port rsp_ready  input  1  response consumer accept.
REQ-010 The block SHALL have port rsp_id  output  1  index of requester that owns the response.
REQ-011 The block SHALL have port rsp_result  output  N  registered ALU result.
REQ-012 The block SHALL have port rsp_flags  output  3  registered {overflow, zero, equal} from the ALU.

Function
REQ-013 The block SHALL instantiate exactly one alu and share it between the two requesters.
REQ-014 The FSM SHALL have states IDLE, EXEC, RESP; IDLE->EXEC on any req handshake, EXEC->RESP unconditionally, RESP->IDLE on rsp_valid && rsp_ready, otherwise hold.
REQ-015 req_ready SHALL be nonzero only in IDLE, equal to the one-hot grant computed combinationally from req_valid.
REQ-016 On handshake the block SHALL latch the granted requester's a, b, control and id into an operand register.
REQ-017 In EXEC the ALU SHALL be driven from the operand register and result plus flags SHALL be captured into rsp_result/rsp_flags at the end of that cycle.
REQ-018 Latency SHALL be fixed: handshake at edge T, rsp_valid high from edge T+2.
REQ-019 rsp_valid SHALL be high exactly in RESP; rsp_id, rsp_result, rsp_flags SHALL be stable while rsp_valid && !rsp_ready.
REQ-020 A new request SHALL NOT be accepted in the cycle the response completes; earliest next handshake is one cycle after RESP->IDLE (3-cycle minimum issue interval).
REQ-021 Requester operand/control changes while its req_ready is low SHALL have no effect.
REQ-022 When exactly one req_valid bit is high in IDLE, that requester SHALL be granted regardless of arbitration policy.
REQ-023 Flags SHALL be passed unmodified from the ALU: overflow only meaningful for ADD/SUB/SLT/SLTU, zero when result is all zeros, equal when a == b.

Reset
REQ-024 Asserting rst low SHALL immediately force state IDLE, req_ready=2'b00 (combinationally derived), rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, operand register=0, last-served pointer=1.
REQ-025 Reset asserted mid-EXEC or mid-RESP SHALL discard the in-flight operation with no response issued.
REQ-026 After rst deasserts, the first rising edge SHALL be able to accept a request.

Configuration
REQ-027 With macro ALU_ARBITER_ROUND_ROBIN_EN defined, contention (both req_valid high in IDLE) SHALL grant the requester not equal to the last-served pointer; the pointer SHALL update to the granted id on every handshake.
REQ-028 Without ALU_ARBITER_ROUND_ROBIN_EN, contention SHALL always grant requester 0 (fixed priority) and the pointer SHALL not exist.

Verification
REQ-029 Single request: req_valid=01, a=5, b=7, control=ALU_ADD, rsp_ready=1 -> rsp_valid at T+2, rsp_id=0, rsp_result=12, rsp_flags=3'b000.
REQ-030 Overflow/flags: req1 a=32'h7FFFFFFF, b=1, ALU_ADD -> rsp_id=1, rsp_result=32'h80000000, overflow=1; req0 a=b=9, ALU_SUB -> result 0, zero=1, equal=1.
REQ-031 Contention: req_valid=11 held for four operations (req0 ADD 1+1, req1 XOR 3^1) -> with ROUND_ROBIN_EN rsp_id sequence 0,1,0,1; without it 0,0,0,0.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_id, rsp_result, rsp_flags unchanged, req_ready=00 throughout; one cycle after rsp_ready=1 handshake, req_ready nonzero again.
REQ-033 Reset mid-op: rst low during EXEC of req0 SLL a=1, b=4 -> rsp_valid=0 immediately, no response after release, next request completes normally with correct result.
REQ-034 Ignored changes: alter req1_a while req_ready=00 during req0's RESP -> req1's later response uses req1_a value present at its own handshake.

Source files
------------

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter (with alu_pkg and alu)
// Description : Shares one combinational ALU between two requesters using a
//               three-state issue pipeline (IDLE -> EXEC -> RESP). A request
//               is latched into an operand register on handshake, evaluated
//               in EXEC and the result/flags are held in RESP until the
//               consumer accepts them.
//               Build option: define ALU_ARBITER_ROUND_ROBIN_EN to arbitrate
//               contention round-robin (last-served pointer); otherwise
//               requester 0 always wins contention.
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous reset, active low
//               req_valid    - [1:0] per-requester operation valid
//               req_ready    - [1:0] one-hot grant, only in IDLE
//               req0_a/b, req1_a/b         - [N-1:0] operands
//               req0_control, req1_control - ALU operation select
//               rsp_valid    - response valid (high exactly in RESP)
//               rsp_ready    - response consumer accept
//               rsp_id       - requester that owns the response
//               rsp_result   - [N-1:0] registered ALU result
//               rsp_flags    - [2:0] registered {overflow, zero, equal}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_control_t;
endpackage

// ----------------------------------------------------------------------------
// Purely combinational ALU. Overflow is the signed overflow of the add or of
// the subtract that the comparison operations are built on; it reads zero for
// all other operations.
// ----------------------------------------------------------------------------
module alu #(
    parameter int N = 32
) (
    input  logic [N-1:0]          a,
    input  logic [N-1:0]          b,
    input  alu_pkg::alu_control_t control,
    output logic [N-1:0]          result,
    output logic                  overflow,
    output logic                  zero,
    output logic                  equal
);
    localparam int c_SHAMT_W = $clog2(N);

    logic [N-1:0]         w_sum;
    logic [N-1:0]         w_diff;
    logic                 w_add_ovf;
    logic                 w_sub_ovf;
    logic                 w_slt;
    logic [c_SHAMT_W-1:0] w_shamt;

    assign w_sum     = a + b;
    assign w_diff    = a - b;
    assign w_add_ovf = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
    assign w_sub_ovf = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
    // Signed less-than: sign of the difference, corrected when it overflowed.
    assign w_slt     = w_diff[N-1] ^ w_sub_ovf;
    assign w_shamt   = b[c_SHAMT_W-1:0];

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (control)
            alu_pkg::ALU_ADD: begin
                result   = w_sum;
                overflow = w_add_ovf;
            end
            alu_pkg::ALU_SUB: begin
                result   = w_diff;
                overflow = w_sub_ovf;
            end
            alu_pkg::ALU_AND: result = a & b;
            alu_pkg::ALU_OR:  result = a | b;
            alu_pkg::ALU_XOR: result = a ^ b;
            alu_pkg::ALU_SLT: begin
                result   = {{(N-1){1'b0}}, w_slt};
                overflow = w_sub_ovf;
            end
            alu_pkg::ALU_SLTU: begin
                result   = {{(N-1){1'b0}}, (a < b)};
                overflow = w_sub_ovf;
            end
            alu_pkg::ALU_SLL: result = a << w_shamt;
            alu_pkg::ALU_SRL: result = a >> w_shamt;
            alu_pkg::ALU_SRA: result = $signed(a) >>> w_shamt;
            default: begin
                result   = '0;
                overflow = 1'b0;
            end
        endcase
    end

    assign zero  = (result == '0);
    assign equal = (a == b);
endmodule

// ----------------------------------------------------------------------------
// Two-requester front end around a single shared ALU.
// ----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [N-1:0]          req0_a,
    input  logic [N-1:0]          req0_b,
    input  logic [N-1:0]          req1_a,
    input  logic [N-1:0]          req1_b,
    input  alu_pkg::alu_control_t req0_control,
    input  alu_pkg::alu_control_t req1_control,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [N-1:0]          rsp_result,
    output logic [2:0]            rsp_flags
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [1:0]            w_grant;
    logic                  w_hs;
    logic                  w_hs_id;

    logic [N-1:0]          r_op_a;
    logic [N-1:0]          r_op_b;
    alu_pkg::alu_control_t r_op_ctl;
    logic                  r_op_id;

    logic [N-1:0]          w_alu_result;
    logic                  w_alu_ovf;
    logic                  w_alu_zero;
    logic                  w_alu_equal;

    logic                  r_rsp_id;
    logic [N-1:0]          r_rsp_result;
    logic [2:0]            r_rsp_flags;

    // ------------------------------------------------------------------
    // Arbitration. A lone requester is always granted; only contention
    // depends on the build option.
    // ------------------------------------------------------------------
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    logic r_last_id;

    always_comb begin
        w_grant = 2'b00;
        case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_id ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_id <= 1'b1;
        end else if (w_hs) begin
            r_last_id <= w_hs_id;
        end
    end
`else
    always_comb begin
        w_grant = 2'b00;
        if (req_valid[0]) begin
            w_grant = 2'b01;
        end else if (req_valid[1]) begin
            w_grant = 2'b10;
        end
    end
`endif

    // Grant is only exposed in IDLE and is forced off while reset is held,
    // so nothing can be accepted before the state register is released.
    assign req_ready = ((r_state == c_IDLE) && rst) ? w_grant : 2'b00;
    assign w_hs      = |req_ready;
    assign w_hs_id   = req_ready[1];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_hs) w_state_nxt = c_EXEC;
            c_EXEC:  w_state_nxt = c_RESP;
            c_RESP:  if (rsp_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand register: loaded only on handshake, so requester inputs are
    // don't-care at every other time.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_ctl <= alu_pkg::ALU_ADD;
            r_op_id  <= 1'b0;
        end else if (w_hs) begin
            r_op_a   <= w_hs_id ? req1_a       : req0_a;
            r_op_b   <= w_hs_id ? req1_b       : req0_b;
            r_op_ctl <= w_hs_id ? req1_control : req0_control;
            r_op_id  <= w_hs_id;
        end
    end

    alu #(
        .N (N)
    ) u_alu (
        .a        (r_op_a),
        .b        (r_op_b),
        .control  (r_op_ctl),
        .result   (w_alu_result),
        .overflow (w_alu_ovf),
        .zero     (w_alu_zero),
        .equal    (w_alu_equal)
    );

    // ------------------------------------------------------------------
    // Response register: captured at the end of EXEC and held through RESP.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= 3'b000;
        end else if (r_state == c_EXEC) begin
            r_rsp_id     <= r_op_id;
            r_rsp_result <= w_alu_result;
            r_rsp_flags  <= {w_alu_ovf, w_alu_zero, w_alu_equal};
        end
    end

    assign rsp_valid  = (r_state == c_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. Expected responses are
//               computed by an independent reference model and queued when a
//               request handshake is observed; they are popped and compared
//               when the DUT completes a response. Define
//               ALU_ARBITER_ROUND_ROBIN_EN for both bench and RTL to exercise
//               the round-robin build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 32;

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic [2:0]  flags;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [N-1:0] req0_a = '0;
    logic [N-1:0] req0_b = '0;
    logic [N-1:0] req1_a = '0;
    logic [N-1:0] req1_b = '0;
    alu_control_t req0_control = ALU_ADD;
    alu_control_t req1_control = ALU_ADD;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_id;
    logic [N-1:0] rsp_result;
    logic [2:0]   rsp_flags;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic tb_last = 1'b1;

    alu_arbiter #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req0_control (req0_control),
        .req1_control (req1_control),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags)
    );

    always #5 clk = ~clk;

    // Reference model: arithmetic done in 64-bit signed to detect overflow.
    function automatic exp_t model(input logic id, input logic [31:0] a,
                                   input logic [31:0] b, input alu_control_t c);
        exp_t        e;
        longint      s;
        logic        ovf;
        logic [31:0] r;
        ovf = 1'b0;
        r   = '0;
        s   = longint'($signed(a)) - longint'($signed(b));
        case (c)
            ALU_ADD: begin
                s   = longint'($signed(a)) + longint'($signed(b));
                r   = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SUB: begin
                r   = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLT: begin
                r   = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SLTU: begin
                r   = (a < b) ? 32'd1 : 32'd0;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SLL: r = a << b[4:0];
            ALU_SRL: r = a >> b[4:0];
            ALU_SRA: r = $signed(a) >>> b[4:0];
            default: r = '0;
        endcase
        e.id     = id;
        e.result = r;
        e.flags  = {ovf, (r == 32'd0), (a == b)};
        return e;
    endfunction

    task automatic drive_req(input int k, input logic [31:0] a, input logic [31:0] b,
                             input alu_control_t c);
        if (k == 0) begin
            req0_a = a; req0_b = b; req0_control = c;
        end else begin
            req1_a = a; req1_b = b; req1_control = c;
        end
        req_valid[k] = 1'b1;
    endtask

    // Drives one request and waits for its handshake; returns at #1 after
    // the handshake edge with the expectation queued.
    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                         input alu_control_t c, output int cycles);
        logic hs;
        drive_req(k, a, b, c);
        cycles = 0;
        hs     = 1'b0;
        while (!hs && cycles < 50) begin
            @(negedge clk);
            hs = req_ready[k];
            @(posedge clk); #1;
            cycles++;
        end
        req_valid[k] = 1'b0;
        if (hs) begin
            sb.push_back(model(k[0], a, b, c));
            tb_last = k[0];
        end else begin
            checks++;
            errors++;
            $display("FAIL issue_timeout req%0d got no grant want grant within 50 cycles", k);
        end
    endtask

    // Waits for a response and returns it once it has completed.
    task automatic get_rsp(output exp_t got, output logic ok);
        int n;
        n   = 0;
        ok  = 1'b0;
        got = '0;
        while (n < 50 && !ok) begin
            if (rsp_valid && rsp_ready) begin
                got.id     = rsp_id;
                got.result = rsp_result;
                got.flags  = rsp_flags;
                ok         = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst     = 1'b1;
        tb_last = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst       = 1'b0;
        req_valid = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_ready got %b want 00", req_ready);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== '0) begin
            errors++;
            $display("FAIL reset_rsp got valid=%b id=%b res=%h flags=%b want all zero",
                     rsp_valid, rsp_id, rsp_result, rsp_flags);
        end
        req_valid = 2'b00;
        rst       = 1'b1;
        tb_last   = 1'b1;
    endtask

    task automatic test_single();
        int   cyc;
        exp_t got, exp;
        logic ok;
        issue(0, 32'd5, 32'd7, ALU_ADD, cyc);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_early got rsp_valid=%b want 0 one edge after handshake", rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency got rsp_valid=%b want 1 two edges after handshake", rsp_valid);
        end
        get_rsp(got, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp || exp !== {1'b0, 32'd12, 3'b000}) begin
            errors++;
            $display("FAIL single_rsp got id=%0d res=%h flags=%b want id=%0d res=%h flags=%b",
                     got.id, got.result, got.flags, exp.id, exp.result, exp.flags);
        end
    endtask

    task automatic test_flags();
        int   cyc;
        exp_t got, exp;
        logic ok;
        issue(1, 32'h7FFF_FFFF, 32'd1, ALU_ADD, cyc);
        get_rsp(got, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL flags_overflow got id=%0d res=%h flags=%b want id=%0d res=%h flags=%b",
                     got.id, got.result, got.flags, exp.id, exp.result, exp.flags);
        end
        issue(0, 32'd9, 32'd9, ALU_SUB, cyc);
        get_rsp(got, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL flags_zero_equal got id=%0d res=%h flags=%b want id=%0d res=%h flags=%b",
                     got.id, got.result, got.flags, exp.id, exp.result, exp.flags);
        end
    endtask

    task automatic test_contention();
        int       n_hs, n_rsp, cyc;
        logic     eg;
        logic [3:0] seq, want_seq;
        exp_t     exp, got;
        pulse_reset();
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
        want_seq = 4'b1010;
`else
        want_seq = 4'b0000;
`endif
        req0_a = 32'd1; req0_b = 32'd1; req0_control = ALU_ADD;
        req1_a = 32'd3; req1_b = 32'd1; req1_control = ALU_XOR;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        n_hs = 0; n_rsp = 0; cyc = 0; seq = 4'b0000;
        while (n_rsp < 4 && cyc < 100) begin
            @(negedge clk);
            if (req_valid == 2'b11 && n_hs < 4 && (req_ready != 2'b00 || rsp_valid == 1'b0)
                && !(dut_busy())) begin
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
                eg = ~tb_last;
`else
                eg = 1'b0;
`endif
                checks++;
                if (req_ready !== (eg ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL contention_grant got %b want %b", req_ready, (eg ? 2'b10 : 2'b01));
                end
                sb.push_back(eg ? model(1'b1, 32'd3, 32'd1, ALU_XOR)
                                : model(1'b0, 32'd1, 32'd1, ALU_ADD));
                tb_last = eg;
                n_hs++;
            end
            if (rsp_valid) begin
                exp = sb.pop_front();
                got.id = rsp_id; got.result = rsp_result; got.flags = rsp_flags;
                seq[n_rsp] = rsp_id;
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL contention_rsp%0d got id=%0d res=%h flags=%b want id=%0d res=%h flags=%b",
                             n_rsp, got.id, got.result, got.flags, exp.id, exp.result, exp.flags);
                end
                n_rsp++;
            end
            @(posedge clk); #1;
            cyc++;
            if (n_hs == 4) req_valid = 2'b00;
        end
        checks++;
        if (n_rsp != 4 || seq !== want_seq) begin
            errors++;
            $display("FAIL contention_order got %0d responses ids(bit i = rsp i)=%b want 4 responses %b",
                     n_rsp, seq, want_seq);
        end
        req_valid = 2'b00;
        sb.delete();
    endtask

    // True when the DUT is not in a state that can accept a request. Derived
    // from the bench's own cycle tracking: a grant is expected only when no
    // response is outstanding in the scoreboard.
    function automatic logic dut_busy();
        return (sb.size() != 0);
    endfunction

    task automatic test_backpressure();
        int   cyc;
        exp_t snap, exp, got;
        logic ok;
        rsp_ready = 1'b0;
        issue(0, 32'd10, 32'd20, ALU_OR, cyc);
        @(posedge clk); #1;
        snap.id = rsp_id; snap.result = rsp_result; snap.flags = rsp_flags;
        exp = sb.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || snap !== exp) begin
            errors++;
            $display("FAIL bp_first got valid=%b id=%0d res=%h flags=%b want valid=1 id=%0d res=%h flags=%b",
                     rsp_valid, snap.id, snap.result, snap.flags, exp.id, exp.result, exp.flags);
        end
        drive_req(1, 32'd4, 32'd2, ALU_SUB);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== snap.id || rsp_result !== snap.result ||
                rsp_flags !== snap.flags || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold%0d got valid=%b id=%0d res=%h flags=%b ready=%b want valid=1 id=%0d res=%h flags=%b ready=00",
                         i, rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready,
                         snap.id, snap.result, snap.flags);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=10", rsp_valid, req_ready);
        end
        issue(1, 32'd4, 32'd2, ALU_SUB, cyc);
        get_rsp(got, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL bp_next got id=%0d res=%h flags=%b want id=%0d res=%h flags=%b",
                     got.id, got.result, got.flags, exp.id, exp.result, exp.flags);
        end
    endtask

    task automatic test_reset_mid_op();
        int   cyc;
        logic seen;
        exp_t got, exp;
        logic ok;
        issue(0, 32'd1, 32'd4, ALU_SLL, cyc);
        rst = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== '0) begin
            errors++;
            $display("FAIL midop_reset got valid=%b id=%b res=%h flags=%b want all zero",
                     rsp_valid, rsp_id, rsp_result, rsp_flags);
        end
        sb.delete();
        @(posedge clk); #1;
        rst     = 1'b1;
        tb_last = 1'b1;
        seen    = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midop_stale got rsp_valid=1 after reset want 0");
        end
        pulse_reset();
        issue(0, 32'd1, 32'd4, ALU_SLL, cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL midop_first_edge got handshake after %0d edges want 1", cyc);
        end
        get_rsp(got, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL midop_next got id=%0d res=%h flags=%b want id=%0d res=%h flags=%b",
                     got.id, got.result, got.flags, exp.id, exp.result, exp.flags);
        end
    endtask

    task automatic test_ignored_changes();
        int   cyc;
        exp_t got, exp;
        logic ok;
        rsp_ready = 1'b0;
        issue(0, 32'd2, 32'd3, ALU_ADD, cyc);
        drive_req(1, 32'd100, 32'd1, ALU_ADD);
        @(posedge clk); #1;
        req1_a = 32'd200;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL ignore_ready got %b want 00 during RESP", req_ready);
        end
        req1_a    = 32'd300;
        rsp_ready = 1'b1;
        get_rsp(got, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL ignore_req0 got id=%0d res=%h flags=%b want id=%0d res=%h flags=%b",
                     got.id, got.result, got.flags, exp.id, exp.result, exp.flags);
        end
        issue(1, 32'd300, 32'd1, ALU_ADD, cyc);
        req1_a = 32'd999;
        req1_b = 32'd999;
        req1_control = ALU_XOR;
        get_rsp(got, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL ignore_req1 got id=%0d res=%h flags=%b want id=%0d res=%h flags=%b",
                     got.id, got.result, got.flags, exp.id, exp.result, exp.flags);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_flags();
        test_contention();
        test_backpressure();
        test_reset_mid_op();
        test_ignored_changes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000 time units");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
